// File: rtl/instruction_fetch_ctrl.sv
// Instruction fetch front-end: owns the PC and issues single-outstanding bus reads.
// Optional FETCH_MISALIGN_CHECK_EN adds o_fetch_misalign and word-aligns jump targets.
module instruction_fetch_ctrl #(
    parameter int unsigned            InstDataBus = 32,
    parameter int unsigned            InstAddrBus = 32,
    parameter int unsigned            HoldFlagBus = 3,
    parameter logic [InstAddrBus-1:0] ResetAddr   = '0
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_jump_flag,
    input  logic [InstAddrBus-1:0] i_jump_addr,
    input  logic [HoldFlagBus-1:0] i_hold_flag,
    output logic                   o_ibus_req,
    output logic [InstAddrBus-1:0] o_ibus_addr,
    input  logic                   i_ibus_gnt,
    input  logic                   i_ibus_rvalid,
    input  logic [InstDataBus-1:0] i_ibus_rdata,
    output logic [InstDataBus-1:0] o_inst_data,
    output logic [InstAddrBus-1:0] o_inst_addr
`ifdef FETCH_MISALIGN_CHECK_EN
    ,
    output logic                   o_fetch_misalign
`endif
);

    localparam logic [HoldFlagBus-1:0] PcHold = HoldFlagBus'(1);
    localparam logic [HoldFlagBus-1:0] IfHold = HoldFlagBus'(2);
    localparam logic [InstDataBus-1:0] Nop    = InstDataBus'(32'h0000_0001);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT
    } state_e;

    state_e                 state_q, state_d;
    logic [InstAddrBus-1:0] pc_q, pc_d;
    logic [InstAddrBus-1:0] req_addr_q, req_addr_d;
    logic [InstDataBus-1:0] buf_data_q, buf_data_d;
    logic [InstAddrBus-1:0] buf_addr_q, buf_addr_d;
    logic                   buf_valid_q, buf_valid_d;
    logic                   discard_q, discard_d;
    logic                   pc_hold, if_hold;
    logic [InstAddrBus-1:0] jump_target;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic                   misalign_q, misalign_d;
`endif

    assign pc_hold = (i_hold_flag >= PcHold);
    assign if_hold = (i_hold_flag >= IfHold);

`ifdef FETCH_MISALIGN_CHECK_EN
    assign jump_target = {i_jump_addr[InstAddrBus-1:2], 2'b00};
`else
    assign jump_target = i_jump_addr;
`endif

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        req_addr_d  = req_addr_q;
        buf_data_d  = buf_data_q;
        buf_addr_d  = buf_addr_q;
        // the IF register takes the entry on every cycle it is not held
        buf_valid_d = buf_valid_q && if_hold;
        discard_d   = discard_q;
        o_ibus_req  = 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
        misalign_d  = i_jump_flag && (i_jump_addr[1:0] != 2'b00);
`endif

        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                o_ibus_req = !pc_hold && !i_jump_flag;
                if (o_ibus_req && i_ibus_gnt) begin
                    req_addr_d = pc_q;
                    pc_d       = pc_q + InstAddrBus'(4);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (i_ibus_rvalid) begin
                    state_d   = REQ;
                    discard_d = 1'b0;
                    if (!discard_q && !i_jump_flag) begin
                        buf_data_d  = i_ibus_rdata;
                        buf_addr_d  = req_addr_q;
                        buf_valid_d = 1'b1;
                    end
                end else if (i_jump_flag) begin
                    // response still in flight belongs to the old path
                    discard_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (i_jump_flag) begin
            pc_d        = jump_target;
            buf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pc_q        <= ResetAddr;
            req_addr_q  <= '0;
            buf_data_q  <= '0;
            buf_addr_q  <= '0;
            buf_valid_q <= 1'b0;
            discard_q   <= 1'b0;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            buf_data_q  <= buf_data_d;
            buf_addr_q  <= buf_addr_d;
            buf_valid_q <= buf_valid_d;
            discard_q   <= discard_d;
`ifdef FETCH_MISALIGN_CHECK_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign o_ibus_addr = pc_q;
    assign o_inst_data = buf_valid_q ? buf_data_q : Nop;
    assign o_inst_addr = buf_valid_q ? buf_addr_q : '0;
`ifdef FETCH_MISALIGN_CHECK_EN
    assign o_fetch_misalign = misalign_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_ctrl.sv
// Bench for instruction_fetch_ctrl: directed vector table, hand sequences, and
// randomized traffic against a transaction-level reference model.
module tb_instruction_fetch_ctrl;

    localparam logic [2:0]  PC_HOLD = 3'd1;
    localparam logic [2:0]  IF_HOLD = 3'd2;
    localparam logic [31:0] NOP     = 32'h0000_0001;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        jump;
    logic [31:0] jaddr;
    logic [2:0]  hold;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ibus_req;
    logic [31:0] ibus_addr;
    logic [31:0] inst_data;
    logic [31:0] inst_addr;
`ifdef FETCH_MISALIGN_CHECK_EN
    logic        misalign;
    logic        m_mis;
`endif

    int errors = 0;
    int checks = 0;

    instruction_fetch_ctrl #(
        .InstDataBus(32),
        .InstAddrBus(32),
        .HoldFlagBus(3),
        .ResetAddr  (32'h0)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_jump_flag  (jump),
        .i_jump_addr  (jaddr),
        .i_hold_flag  (hold),
        .o_ibus_req   (ibus_req),
        .o_ibus_addr  (ibus_addr),
        .i_ibus_gnt   (gnt),
        .i_ibus_rvalid(rvalid),
        .i_ibus_rdata (rdata),
        .o_inst_data  (inst_data),
        .o_inst_addr  (inst_addr)
`ifdef FETCH_MISALIGN_CHECK_EN
        ,
        .o_fetch_misalign(misalign)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        jump;
        logic [31:0] jaddr;
        logic [2:0]  hold;
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic [31:0] exp_data;
        logic [31:0] exp_iaddr;
    } vec_t;

    vec_t vecs [27];

    // reference model state: transaction level, one outstanding read at most
    logic        m_started, m_out, m_stale, m_bv;
    logic [31:0] m_pc, m_oaddr, m_bd, m_ba;

    function automatic vec_t v(input logic j, input logic [31:0] ja, input logic [2:0] h,
                               input logic g, input logic rv, input logic [31:0] rd,
                               input logic er, input logic [31:0] ea,
                               input logic [31:0] ed, input logic [31:0] ei);
        vec_t r;
        r.jump = j; r.jaddr = ja; r.hold = h; r.gnt = g; r.rvalid = rv; r.rdata = rd;
        r.exp_req = er; r.exp_addr = ea; r.exp_data = ed; r.exp_iaddr = ei;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic j, input logic [31:0] ja, input logic [2:0] h,
                          input logic g, input logic rv, input logic [31:0] rd);
        jump = j; jaddr = ja; hold = h; gnt = g; rvalid = rv; rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic model_reset();
        m_started = 1'b0; m_out = 1'b0; m_stale = 1'b0; m_bv = 1'b0;
        m_pc = 32'h0; m_oaddr = 32'h0; m_bd = 32'h0; m_ba = 32'h0;
`ifdef FETCH_MISALIGN_CHECK_EN
        m_mis = 1'b0;
`endif
    endtask

    task automatic do_reset();
        set_in(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic        j, g, rv, ld, exp_req, ph, ih;
        logic [31:0] ja, rd, tgt;
        logic [2:0]  h;

        vecs[0]  = v(0, 0, 0, 0, 0, 0,            0, 32'h000, NOP, 0);
        vecs[1]  = v(0, 0, 0, 1, 0, 0,            1, 32'h000, NOP, 0);
        vecs[2]  = v(0, 0, 0, 0, 1, 32'h00500093, 0, 32'h004, NOP, 0);
        vecs[3]  = v(0, 0, 0, 0, 0, 0,            1, 32'h004, 32'h00500093, 32'h0);
        vecs[4]  = v(0, 0, 0, 0, 0, 0,            1, 32'h004, NOP, 0);
        vecs[5]  = v(0, 0, 0, 0, 0, 0,            1, 32'h004, NOP, 0);
        vecs[6]  = v(0, 0, 0, 1, 0, 0,            1, 32'h004, NOP, 0);
        vecs[7]  = v(0, 0, 0, 0, 1, 32'h00100113, 0, 32'h008, NOP, 0);
        vecs[8]  = v(0, 0, 0, 1, 0, 0,            1, 32'h008, 32'h00100113, 32'h4);
        vecs[9]  = v(0, 0, 0, 0, 1, 32'h00208193, 0, 32'h00C, NOP, 0);
        for (int unsigned i = 10; i < 14; i++)
            vecs[i] = v(0, 0, IF_HOLD, 1, 0, 0,   0, 32'h00C, 32'h00208193, 32'h8);
        vecs[14] = v(0, 0, 0, 0, 0, 0,            1, 32'h00C, 32'h00208193, 32'h8);
        vecs[15] = v(0, 0, 0, 1, 0, 0,            1, 32'h00C, NOP, 0);
        vecs[16] = v(0, 0, 0, 0, 1, 32'h0030A023, 0, 32'h010, NOP, 0);
        vecs[17] = v(0, 0, 0, 1, 0, 0,            1, 32'h010, 32'h0030A023, 32'hC);
        vecs[18] = v(1, 32'h100, 0, 0, 0, 0,      0, 32'h014, NOP, 0);
        vecs[19] = v(0, 0, 0, 0, 0, 0,            0, 32'h100, NOP, 0);
        vecs[20] = v(0, 0, 0, 0, 1, 32'hDEADBEEF, 0, 32'h100, NOP, 0);
        vecs[21] = v(0, 0, 0, 1, 0, 0,            1, 32'h100, NOP, 0);
        vecs[22] = v(1, 32'h200, 0, 0, 1, 32'h11111111, 0, 32'h104, NOP, 0);
        vecs[23] = v(0, 0, 0, 0, 0, 0,            1, 32'h200, NOP, 0);
        vecs[24] = v(0, 0, 0, 1, 0, 0,            1, 32'h200, NOP, 0);
        vecs[25] = v(0, 0, 0, 0, 1, 32'h22222222, 0, 32'h204, NOP, 0);
        vecs[26] = v(0, 0, 0, 0, 0, 0,            1, 32'h204, 32'h22222222, 32'h200);

        do_reset();
        for (int unsigned i = 0; i < 27; i++) begin
            set_in(vecs[i].jump, vecs[i].jaddr, vecs[i].hold,
                   vecs[i].gnt, vecs[i].rvalid, vecs[i].rdata);
            #1;
            check($sformatf("vec%0d req", i),   ibus_req,  vecs[i].exp_req);
            check($sformatf("vec%0d addr", i),  ibus_addr, vecs[i].exp_addr);
            check($sformatf("vec%0d data", i),  inst_data, vecs[i].exp_data);
            check($sformatf("vec%0d iaddr", i), inst_addr, vecs[i].exp_iaddr);
            tick();
        end

`ifdef FETCH_MISALIGN_CHECK_EN
        set_in(1'b1, 32'h102, 3'd0, 1'b0, 1'b0, 32'h0);
        #1;
        check("mis pre", misalign, 1'b0);
        check("mis jump req", ibus_req, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
        #1;
        check("mis pulse", misalign, 1'b1);
        check("mis addr", ibus_addr, 32'h100);
        check("mis req", ibus_req, 1'b1);
        tick();
        #1;
        check("mis clear", misalign, 1'b0);
`endif

        // PC wrap and asynchronous reset with a valid entry and an active request
        set_in(1'b1, 32'hFFFFFFFC, 3'd0, 1'b0, 1'b0, 32'h0);
        #1; check("wrap jump req", ibus_req, 1'b0);
        tick();
        set_in(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);
        #1; check("wrap req", ibus_req, 1'b1); check("wrap addr", ibus_addr, 32'hFFFFFFFC);
        tick();
        set_in(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h33333333);
        #1; check("wrap pc", ibus_addr, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 3'd0, 1'b1, 1'b0, 32'h0);
        #1; check("wrap data", inst_data, 32'h33333333);
        check("wrap iaddr", inst_addr, 32'hFFFFFFFC);
        check("wrap next addr", ibus_addr, 32'h0);
        tick();
        set_in(1'b0, 32'h0, 3'd0, 1'b0, 1'b1, 32'h44444444);
        tick();
        set_in(1'b0, 32'h0, 3'd0, 1'b0, 1'b0, 32'h0);
        #1; check("pre-rst data", inst_data, 32'h44444444); check("pre-rst req", ibus_req, 1'b1);
        rst_n = 1'b0;
        #1; check("async rst req", ibus_req, 1'b0); check("async rst addr", ibus_addr, 32'h0);
        check("async rst data", inst_data, NOP); check("async rst iaddr", inst_addr, 32'h0);

        do_reset();
        for (int unsigned n = 0; n < 3000; n++) begin
            j  = ($urandom_range(0, 99) < 8);
            case ($urandom_range(0, 3))
                0:       ja = 32'hFFFFFFFC;
                1:       ja = $urandom;
                default: ja = $urandom & ~32'h3;
            endcase
            h  = ($urandom_range(0, 9) < 6) ? 3'd0 : 3'($urandom_range(1, 7));
            g  = ($urandom_range(0, 2) != 0);
            rv = m_out ? ($urandom_range(0, 2) != 0) : ($urandom_range(0, 19) == 0);
            rd = $urandom;
            set_in(j, ja, h, g, rv, rd);
            #1;
            ph = (h >= PC_HOLD);
            ih = (h >= IF_HOLD);
            exp_req = m_started && !m_out && !ph && !j;
            check("rnd req",   ibus_req,  exp_req);
            check("rnd addr",  ibus_addr, m_pc);
            check("rnd data",  inst_data, m_bv ? m_bd : NOP);
            check("rnd iaddr", inst_addr, m_bv ? m_ba : 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
            check("rnd misalign", misalign, m_mis);
`endif
            @(posedge clk);
            ld = 1'b0;
            if (rv && m_out) begin
                ld = !m_stale && !j;
                m_out = 1'b0;
                m_stale = 1'b0;
            end else if (j && m_out) begin
                m_stale = 1'b1;
            end
            if (ld) begin
                m_bv = 1'b1; m_bd = rd; m_ba = m_oaddr;
            end else if (j || !ih) begin
                m_bv = 1'b0;
            end
            if (exp_req && g) begin
                m_out = 1'b1; m_oaddr = m_pc; m_pc = m_pc + 32'd4;
            end
`ifdef FETCH_MISALIGN_CHECK_EN
            tgt = {ja[31:2], 2'b00};
            m_mis = j && (ja[1:0] != 2'b00);
`else
            tgt = ja;
`endif
            if (j) m_pc = tgt;
            m_started = 1'b1;
            @(negedge clk);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
